// File: rtl/rotseq_pkg.sv
// Shared types and constants for the rotate/invert pattern sequencer.
package rotseq_pkg;

  localparam int unsigned PAT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] PH_ROL1 = 2'd0;
  localparam logic [1:0] PH_ROL2 = 2'd1;
  localparam logic [1:0] PH_ROL3 = 2'd2;
  localparam logic [1:0] PH_INV  = 2'd3;

endpackage

// File: rtl/rotseq_op.sv
// Combinational op decode: (phase, operand) -> result, shared with the datapath.
module rotseq_op
  import rotseq_pkg::*;
(
  input  logic [1:0]       phase,
  input  logic [PAT_W-1:0] operand,
  output logic [PAT_W-1:0] result
);

  always_comb begin
    result = operand;
    case (phase)
      PH_ROL1: result = {operand[2:0], operand[3]};
      PH_ROL2: result = {operand[1:0], operand[3:2]};
      PH_ROL3: result = {operand[0], operand[3:1]};
      PH_INV:  result = ~operand;
      default: result = operand;
    endcase
  end

endmodule

// File: rtl/rotate_sequencer.sv
// Runs a bounded sequence of rotate/invert steps over a valid/ready output.
// Optional feature: ROTSEQ_PAUSE_EN adds a pause input that freezes RUN.
module rotate_sequencer
  import rotseq_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] count_in,
  output logic [PAT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [PAT_W-1:0] final_pat
`ifdef ROTSEQ_PAUSE_EN
  ,
  input  logic             pause
`endif
);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] steps_q;
  logic [1:0]       phase_q;
  logic [PAT_W-1:0] op_res;
  logic             load, adv, run_en;

`ifdef ROTSEQ_PAUSE_EN
  assign run_en = ~pause;
`else
  assign run_en = 1'b1;
`endif

  rotseq_op u_op (
    .phase   (phase_q),
    .operand (pat_q),
    .result  (op_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    adv       = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_data  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (count_in == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        out_valid = run_en;
        // out_data stays driven while paused so the same value reappears on release
        out_data  = op_res;
        if (out_valid && out_ready) begin
          adv = 1'b1;
          if (steps_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= '0;
      steps_q <= '0;
      phase_q <= PH_ROL1;
    end else if (load) begin
      pat_q   <= pattern_in;
      steps_q <= count_in;
      phase_q <= PH_ROL1;
    end else if (adv) begin
      pat_q   <= op_res;
      steps_q <= steps_q - CNT_W'(1);
      phase_q <= phase_q + 2'd1;
    end
  end

  assign final_pat = pat_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Randomized self-checking bench for rotate_sequencer against a step-list model.
module tb_rotate_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, out_ready;
  logic             out_valid, busy, done;
  logic [3:0]       pattern_in, out_data, final_pat;
  logic [CNT_W-1:0] count_in;
`ifdef ROTSEQ_PAUSE_EN
  logic             pause;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rotate_sequencer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pattern_in (pattern_in),
    .count_in   (count_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .final_pat  (final_pat)
`ifdef ROTSEQ_PAUSE_EN
    ,
    .pause      (pause)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step k of a sequence: rotate left by (k mod 4)+1, except every fourth step inverts.
  function automatic logic [3:0] ref_op(input int step, input logic [3:0] p);
    int k = step % 4;
    int v = int'(p);
    if (k == 3) return ~p;
    return 4'(((v << (k + 1)) | (v >> (3 - k))) & 15);
  endfunction

  task automatic run_seq(input logic [3:0] pat, input int cnt, input int ready_pct,
                         input bit poke, output logic [3:0] fin_pat);
    logic [3:0] mp;
    int ph, left;
    bit hs, fin;
    start      = 1'b1;
    pattern_in = pat;
    count_in   = CNT_W'(cnt);
    out_ready  = 1'b0;
    @(negedge clk);
    start      = 1'b0;
    pattern_in = 4'($urandom);
    count_in   = CNT_W'($urandom);
    mp = pat; ph = 0; left = cnt; fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (left > 0) begin
        check("valid", out_valid, 1);
        check("data", out_data, ref_op(ph, mp));
        check("busy_run", busy, 1);
        check("done_early", done, 0);
        out_ready = ($urandom_range(0, 99) < ready_pct);
        hs = out_ready;
        if (poke && cyc == 0) begin
          start      = 1'b1;
          pattern_in = 4'hF;
          count_in   = CNT_W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        if (hs) begin
          mp = ref_op(ph, mp);
          ph++;
          left--;
        end
      end else begin
        check("done", done, 1);
        check("valid_done", out_valid, 0);
        check("busy_done", busy, 1);
        check("final_pat", final_pat, mp);
        fin = 1'b1;
      end
    end
    check("timeout", fin, 1);
    out_ready = 1'b0;
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("done_idle", done, 0);
    check("valid_idle", out_valid, 0);
    check("final_idle", final_pat, mp);
    fin_pat = mp;
  endtask

  logic [3:0] f;

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    pattern_in = '0; count_in = '0;
`ifdef ROTSEQ_PAUSE_EN
    pause = 1'b0;
`endif
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_final", final_pat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq(4'b0001, 4, 100, 1'b0, f);
    check("basic_final", f, 4'b1011);
    run_seq(4'b0001, 5, 100, 1'b0, f);
    check("wrap_final", f, 4'b0111);
    run_seq(4'b0001, 4, 50, 1'b1, f);
    check("bp_busy_final", f, 4'b1011);
    run_seq(4'b1010, 0, 100, 1'b0, f);
    check("zero_final", f, 4'b1010);

    // Asynchronous reset in the middle of a run.
    start = 1'b1; pattern_in = 4'b0110; count_in = CNT_W'(8);
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_final", final_pat, 0);
    @(posedge clk);
    #1 check("mid_rst_nodone", done, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("post_rst_done", done, 0);
    run_seq(4'b0001, 4, 100, 1'b0, f);
    check("post_rst_final", f, 4'b1011);

    for (int i = 0; i < 25; i++)
      run_seq(4'($urandom), $urandom_range(0, 15), $urandom_range(20, 100),
              1'($urandom_range(0, 1)), f);

`ifdef ROTSEQ_PAUSE_EN
    start = 1'b1; pattern_in = 4'b0011; count_in = CNT_W'(3);
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    check("pz_valid0", out_valid, 1);
    check("pz_data0", out_data, ref_op(0, 4'b0011));
    pause = 1'b1;
    @(negedge clk);
    check("pz_hold1", out_valid, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("pz_hold2", out_valid, 0);
    pause = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("pz_valid1", out_valid, 1);
    check("pz_data1", out_data, ref_op(0, 4'b0011));
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    check("pz_idle", busy, 0);
    check("pz_final", final_pat, ref_op(2, ref_op(1, ref_op(0, 4'b0011))));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotate_sequencer.md
# rotate_sequencer

Sequencer for the 4-bit rotate/invert pattern datapath. It takes over the job of the free-running 2-bit phase counter: it loads a pattern, then applies a programmed number of steps, cycling the op phase 0→1→2→3→0. Each step's result is emitted over a valid/ready handshake and fed back as the next step's operand. Start/busy/done control lets a host processor or testbench run bounded sequences.

## Interface
- CNT_W, default 4: width of the step-count input and the internal step counter.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a sequence; sampled only in IDLE.
- pattern_in  input  4  initial operand, latched on an accepted start.
- count_in  input  CNT_W  number of steps to run, latched on an accepted start; 0 is legal.
- out_data  output  4  result of the current step.
- out_valid  output  1  out_data holds a step result.
- out_ready  input  1  consumer accepts out_data in any cycle where out_valid=1.
- busy  output  1  a sequence is in progress (state RUN or DONE).
- done  output  1  one-cycle pulse when a sequence completes.
- final_pat  output  4  operand register; after a sequence it holds the last accepted result.
- pause  input  1  present only with ROTSEQ_PAUSE_EN.

## Operation
- State machine: IDLE, RUN, DONE.
- Op by phase, with p = operand register:
  - phase 0: rotate left 1, {p[2],p[1],p[0],p[3]}.
  - phase 1: rotate left 2.
  - phase 2: rotate left 3.
  - phase 3: bitwise invert ~p.
- IDLE:
  - start=1 → pat←pattern_in, steps←count_in, phase←0.
  - Next state is RUN; if count_in=0, next state is DONE instead.
  - start=0 → stay in IDLE.
- RUN:
  - out_valid=1; out_data = op(phase, pat), decoded combinationally from registers.
  - On out_valid & out_ready: pat←out_data, phase←phase+1 (3 wraps to 0), steps←steps−1.
  - If steps was 1 at that handshake → DONE.
  - No handshake → all registers hold.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored while busy=1; no queuing.
- pattern_in and count_in are don't-care outside an accepted start.
- Phase always restarts at 0 on each new sequence.

## Timing
- Reset (asynchronous, effective immediately):
  - State IDLE; pat=0, steps=0, phase=0.
  - out_valid=0, busy=0, done=0, out_data=0, final_pat=0.
  - Reset mid-sequence aborts it; no done pulse is generated.
- Latency:
  - Start accepted in cycle n → out_valid=1 from cycle n+1.
  - With out_ready held high, one result per cycle.
  - An N-step sequence raises done in cycle n+N+1; a count of 0 raises done in cycle n+1.
- Stall: while out_valid=1 and out_ready=0, out_data stays stable.
- out_valid never drops without a handshake except on reset.
- busy=1 in RUN and DONE; start is accepted again in the cycle after done.
- Wrap: the step counter never underflows. Phase wraps modulo 4.

## Configuration
- ROTSEQ_PAUSE_EN defined:
  - Adds the pause port.
  - pause=1 in RUN forces out_valid=0 and freezes pat, phase and steps.
  - Releasing pause resumes with the same out_data.
  - pause in IDLE or DONE has no effect.
- ROTSEQ_PAUSE_EN undefined: there is no pause port and no pause logic; behaviour is as above.

## Structure
- Package rotseq_pkg holds:
  - The state enum (IDLE, RUN, DONE).
  - Phase encoding constants PH_ROL1, PH_ROL2, PH_ROL3, PH_INV.
  - The pattern width constant PAT_W=4.
- Sub-module rotseq_op: purely combinational (phase, operand) → result. It is shared with the datapath so both use identical op decoding.
- The FSM, counters and operand register live in rotate_sequencer.

## Test plan
- Reset mid-run: assert rst_n=0 during RUN → all outputs 0 immediately; no done pulse; next start runs normally from phase 0.
- Basic sequence: pattern_in=4'b0001, count_in=4, out_ready=1 → out_data 0010, 1000, 0100, 1011 on consecutive cycles; done in the following cycle; final_pat=1011.
- Phase wrap: same pattern as above with count_in=5 → fifth result is 0111 (rotate left 1 of 1011).
- Backpressure: out_ready low for 3 cycles during step 2 → out_data holds 1000 and out_valid stays 1; sequence resumes with no lost or duplicated step.
- Zero count: count_in=0 → out_valid never asserts; done in cycle n+1; final_pat=pattern_in.
- Start while busy: pulse start with pattern_in=4'b1111 during RUN → ignored; original results unchanged.
- With ROTSEQ_PAUSE_EN: pause=1 for 2 cycles in RUN → out_valid=0 throughout, then the same out_data reappears after release.
